// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU constants and types. Holds the sram-like bus size
//                encodings, the boot/exception vectors and the prefetch queue
//                entry layout used by inst_prefetch and prefetch_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // sram-like transfer size encodings
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Boot and general exception vectors
    localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'hbfc0_0380;

    // One prefetch queue entry: {pc, inst, adel}
    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : Circular instruction queue for the prefetcher. Pointers wrap
//                modulo DEPTH (power of two); full means count == DEPTH.
//                The caller reserves space before pushing, so no overflow
//                guard is applied here. i_clr empties the queue synchronously.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_clr           - flush all entries
//                i_push / i_din  - write one entry at the tail
//                i_pop           - drop the head entry
//                o_dout          - head entry (valid when !o_empty)
//                o_empty, o_count- occupancy status
// ============================================================================
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    // Storage needs no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (c_AW+1)'(i_push) - (c_AW+1)'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : prefetch_fifo
`default_nettype wire

// File: rtl/inst_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch
//  Description : Instruction prefetcher with an sram-like read master and a
//                DEPTH-entry queue. Queue space is reserved when a request is
//                accepted, so responses can always be written. A redirect
//                flushes the queue and discards responses still in flight for
//                the old stream; a request caught mid-handshake is held until
//                accepted and its response discarded too. A misaligned fetch
//                PC produces one address-error entry and halts fetching until
//                the next redirect.
//  Revision    : 1.0 - initial release
//  Macro       : INST_PREFETCH_STATS_EN - adds stat_fetch_cnt/stat_drop_cnt
//  Ports       : clk, rst                 - clock, sync active-high reset
//                redirect_valid/_pc       - start a new fetch stream
//                out_valid/pc/inst/adel   - queue head, out_ready pops it
//                inst_req..inst_wdata     - sram-like request channel
//                inst_rdata/addr_ok/data_ok - sram-like responses
//                stat_fetch_cnt/drop_cnt  - accepted requests / discarded
//                                           responses (optional)
// ============================================================================
module inst_prefetch
    import cpu_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel,
    input  logic        out_ready,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok
`ifdef INST_PREFETCH_STATS_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_drop_cnt
`endif
);

    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;     // next address of the current stream
    logic [31:0]   r_resp_pc;      // PC belonging to the next kept response
    logic [31:0]   r_hold_addr;    // old-stream address held across redirect
    logic          r_hold_valid;
    logic          r_adel_stop;    // address-error entry already issued
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;

    logic [c_CW-1:0] w_fifo_count;
    logic            w_fifo_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic [c_CW:0]   w_inflight;
    logic            w_misaligned;
    logic            w_new_req;
    logic            w_accept;
    logic            w_accept_held;
    logic            w_resp;
    logic            w_discard;
    logic            w_push_resp;
    logic            w_push_adel;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_outstanding_next;

    assign inst_wr    = 1'b0;
    assign inst_size  = SIZE_WORD;
    assign inst_wdata = 32'h0;

    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign w_inflight   = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_new_req    = !w_misaligned && !r_adel_stop
                       && (r_outstanding < c_CW'(MAX_OUTSTANDING))
                       && (w_inflight < (c_CW+1)'(DEPTH));

    // A held old-stream request takes priority; the new stream waits for it.
    assign inst_req  = !rst && (r_hold_valid || w_new_req);
    assign inst_addr = r_hold_valid ? r_hold_addr : r_fetch_pc;

    assign w_accept      = inst_req && inst_addr_ok;
    assign w_accept_held = w_accept && r_hold_valid;
    assign w_resp        = !rst && inst_data_ok && (r_outstanding != '0);
    assign w_discard     = w_resp && ((r_drop_cnt != '0) || redirect_valid);
    assign w_push_resp   = w_resp && !w_discard;
    assign w_push_adel   = w_misaligned && !r_adel_stop && !r_hold_valid
                        && (r_outstanding == '0)
                        && (w_fifo_count < c_CW'(DEPTH))
                        && !redirect_valid;
    assign w_push        = w_push_resp || w_push_adel;
    assign w_pop         = out_valid && out_ready && !redirect_valid;

    assign w_outstanding_next = r_outstanding + c_CW'(w_accept) - c_CW'(w_resp);

    // Response and address-error pushes are exclusive: the latter needs
    // nothing outstanding.
    always_comb begin
        w_push_entry = '0;
        if (w_push_adel) begin
            w_push_entry.pc   = r_fetch_pc;
            w_push_entry.inst = 32'h0;
            w_push_entry.adel = 1'b1;
        end else begin
            w_push_entry.pc   = r_resp_pc;
            w_push_entry.inst = inst_rdata;
            w_push_entry.adel = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_hold_addr   <= RESET_PC;
            r_hold_valid  <= 1'b0;
            r_adel_stop   <= 1'b0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the
                // old stream, including a request accepted right now.
                r_fetch_pc   <= redirect_pc;
                r_resp_pc    <= redirect_pc;
                r_drop_cnt   <= w_outstanding_next;
                r_adel_stop  <= 1'b0;
                r_hold_valid <= inst_req && !inst_addr_ok;
                r_hold_addr  <= inst_addr;
            end else begin
                if (w_accept && !r_hold_valid) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_accept_held) begin
                    r_hold_valid <= 1'b0;
                end
                // Discard here implies drop_cnt > 0; a held request joins the
                // drop count only once the slave takes it.
                r_drop_cnt <= r_drop_cnt - c_CW'(w_discard) + c_CW'(w_accept_held);
                if (w_push_resp) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_push_adel) begin
                    r_adel_stop <= 1'b1;
                end
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (redirect_valid),
        .i_push  (w_push && !redirect_valid),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_valid = !rst && !w_fifo_empty;
    assign out_pc    = w_head.pc;
    assign out_inst  = w_head.inst;
    assign out_adel  = w_head.adel;

`ifdef INST_PREFETCH_STATS_EN
    logic [31:0] r_stat_fetch;
    logic [31:0] r_stat_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetch <= '0;
            r_stat_drop  <= '0;
        end else begin
            r_stat_fetch <= r_stat_fetch + 32'(w_accept);
            r_stat_drop  <= r_stat_drop + 32'(w_discard);
        end
    end

    assign stat_fetch_cnt = r_stat_fetch;
    assign stat_drop_cnt  = r_stat_drop;
`endif

endmodule : inst_prefetch
`default_nettype wire

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, accepted-but-unanswered bus requests (1..DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'hbfc00000, first fetch address.
REQ-004 SHALL have ports, in this order:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- redirect_valid, input, 1: new fetch stream request (branch/exception/eret).
- redirect_pc, input, 32: new fetch address.
- out_valid, output, 1: head entry valid.
- out_pc, output, 32: head PC.
- out_inst, output, 32: head instruction.
- out_adel, output, 1: head PC misaligned.
- out_ready, input, 1: consumer pops head.
- inst_req, inst_wr, inst_size, inst_addr, inst_wdata: output, 1/1/2/32/32, sram-like master.
- inst_rdata, input, 32; inst_addr_ok, inst_data_ok, input, 1: sram-like responses.

Function
REQ-005 SHALL drive inst_wr=0, inst_size=2'b10, inst_wdata=0 constantly.
REQ-006 SHALL raise inst_req when no adel stop, outstanding<MAX_OUTSTANDING, and occupancy+outstanding<DEPTH.
REQ-007 SHALL hold inst_req and inst_addr stable until inst_addr_ok; on acceptance, fetch_pc += 4 and outstanding += 1.
REQ-008 SHALL assume in-order responses; each inst_data_ok decrements outstanding.
REQ-009 SHALL write a non-dropped response into the queue, so out_valid rises the cycle after inst_data_ok. Latency: 1 cycle.
REQ-010 SHALL pop the head when out_valid && out_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-011 SHALL never overflow; space is reserved at request acceptance per REQ-006.
REQ-012 On redirect_valid, SHALL:
- clear the queue;
- set fetch_pc=redirect_pc;
- set drop_cnt = outstanding after this cycle's acceptances and responses, i.e. include a request accepted this cycle and exclude a response arriving this cycle.
REQ-013 SHALL discard a response arriving while drop_cnt>0, decrementing drop_cnt, and SHALL also discard any response arriving in the same cycle as redirect_valid.
REQ-014 If redirect_valid arrives while inst_req is high without inst_addr_ok, SHALL keep that request and its address until accepted, then count it in drop_cnt. New-stream requests SHALL start only afterwards.
REQ-015 Redirect wins over a same-cycle pop or push.
REQ-016 If fetch_pc[1:0]!=0, SHALL:
- issue no bus request;
- push one entry with out_adel=1, out_pc=fetch_pc, out_inst=0 once the queue has space and outstanding==0;
- stop fetching until the next redirect.
REQ-017 SHALL keep out_pc/out_inst/out_adel stable while out_valid && !out_ready.
REQ-018 SHALL make the queue pointers wrap modulo DEPTH; the full condition is occupancy==DEPTH.

Reset
REQ-019 When rst, SHALL set fetch_pc=RESET_PC, set outstanding, drop_cnt and occupancy to 0, drive out_valid=0 and inst_req=0, and clear the adel stop.
REQ-020 SHALL make inst_req rise earliest the cycle after rst deasserts.
REQ-021 rst mid-transaction SHALL forget outstanding requests. Environment SHALL reset the bus slave concurrently.

Configuration
REQ-022 Macro INST_PREFETCH_STATS_EN defined: SHALL add outputs stat_fetch_cnt and stat_drop_cnt, 32 bits each, wrapping. They count accepted requests and discarded responses respectively, and are reset to 0.
REQ-023 Macro undefined: SHALL omit those ports and counters, with otherwise identical behaviour.

Structure
REQ-024 SHALL define the sram-like size encodings (SIZE_WORD=2'b10) and the RESET_PC/exception vector constants in shared package cpu_pkg.
REQ-025 SHALL place queue storage and pointers in sub-module prefetch_fifo, parameterised by DEPTH and WIDTH=65 (pc, inst, adel).

Verification
REQ-026 Scenario: slave with 0-wait addr_ok and 1-cycle data_ok, out_ready=1. Required: outputs pc 0xbfc00000, 0xbfc00004, ... in order, with at most MAX_OUTSTANDING outstanding.
REQ-027 Scenario: out_ready=0. Required: exactly DEPTH=4 entries are fetched, inst_req stays low afterwards, and out_pc holds 0xbfc00000.
REQ-028 Scenario: 2 requests outstanding, then redirect_pc=0x80001000. Required: both responses are dropped, the next out_pc is 0x80001000, and stat_drop_cnt=2.
REQ-029 Scenario: redirect while inst_req is pending with addr_ok held low for 3 cycles. Required: inst_addr stays at the old value until accepted, that response is dropped, then 0x80001000 is fetched.
REQ-030 Scenario: redirect_pc=0x80000002. Required: no inst_req, one entry with out_adel=1 and out_pc=0x80000002, then idle until the next redirect.
REQ-031 Scenario: inst_data_ok and redirect_valid in the same cycle. Required: that response is discarded and the queue is empty the next cycle.
